data_bus_decoder: RTL and testbench

Wishbone classic address decoder placed directly downstream of the core's data memory access state machine. It takes the single master data bus (CYC/STB/WE/ADR/DAT_O/DAT_I/ACK) and routes each cycle to the data RAM slave or the I/O slave by address. Unmapped addresses and stalled slaves get a one-cycle error acknowledge, so the core's load/store sequencer can never hang. It also keeps a saturating count of bus errors for debug.

---
 rtl/data_bus_decoder_if.sv | 13 +
 rtl/data_bus_decoder.sv | 123 ++++++++++++
 tb/tb_data_bus_decoder.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_bus_decoder_if.sv
// Wishbone classic point-to-point bus. Modports are named from the bus master's and the slave's side.
interface data_bus_decoder_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack;

  modport master (output cyc, stb, we, adr, dat_o, input dat_i, ack);
  modport slave  (input cyc, stb, we, adr, dat_o, output dat_i, ack);
endinterface

// File: rtl/data_bus_decoder.sv
// Wishbone classic data-bus decoder: routes the master to RAM (s0) or I/O (s1) and error-acks unmapped or stalled cycles.
// Latency: the slave is strobed one cycle after decode, and m_ack passes through combinationally; a slave stall ends in an error ack after TIMEOUT cycles.
module data_bus_decoder #(
  parameter logic [31:0] S0_BASE = 32'h0000_0000,
  parameter logic [31:0] S0_MASK = 32'hFFFF_0000,
  parameter logic [31:0] S1_BASE = 32'h1000_0000,
  parameter logic [31:0] S1_MASK = 32'hFFFF_F000,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  data_bus_decoder_if.slave         m_bus,
  data_bus_decoder_if.master        s0_bus,
  data_bus_decoder_if.master        s1_bus,
  output logic                      m_err,
  output logic [7:0]                err_count
);

  typedef enum logic [1:0] { IDLE, SEL0, SEL1, ERROR } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] tmo_cnt;
  logic [7:0] tmo_cnt_nxt;
  logic       req;
  logic       s0_hit;
  logic       s1_hit;

  assign req    = m_bus.cyc & m_bus.stb;
  assign s0_hit = (m_bus.adr & S0_MASK) == S0_BASE;
  assign s1_hit = (m_bus.adr & S1_MASK) == S1_BASE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      err_count <= '0;
    end else begin
      state   <= state_nxt;
      tmo_cnt <= tmo_cnt_nxt;
      if (state == ERROR && err_count != 8'hFF) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

  // Outputs are forced low while rst is high so an interrupted transfer never leaks a strobe or ack.
  always_comb begin
    state_nxt    = state;
    tmo_cnt_nxt  = '0;
    m_bus.ack    = 1'b0;
    m_bus.dat_i  = '0;
    m_err        = 1'b0;
    s0_bus.cyc   = 1'b0;
    s0_bus.stb   = 1'b0;
    s0_bus.we    = 1'b0;
    s0_bus.adr   = '0;
    s0_bus.dat_o = '0;
    s1_bus.cyc   = 1'b0;
    s1_bus.stb   = 1'b0;
    s1_bus.we    = 1'b0;
    s1_bus.adr   = '0;
    s1_bus.dat_o = '0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (req) begin
            if (s0_hit) begin
              state_nxt = SEL0;
            end else if (s1_hit) begin
              state_nxt = SEL1;
            end else begin
              state_nxt = ERROR;
            end
          end
        end
        SEL0: begin
          s0_bus.cyc   = m_bus.cyc;
          s0_bus.stb   = m_bus.stb;
          s0_bus.we    = m_bus.we;
          s0_bus.adr   = m_bus.adr;
          s0_bus.dat_o = m_bus.dat_o;
          m_bus.dat_i  = s0_bus.dat_i;
          m_bus.ack    = s0_bus.ack & m_bus.stb;
          if (!m_bus.stb || s0_bus.ack) begin
            state_nxt = IDLE;
          end else if (tmo_cnt == TMO_LAST) begin
            state_nxt = ERROR;
          end else begin
            tmo_cnt_nxt = tmo_cnt + 8'd1;
          end
        end
        SEL1: begin
          s1_bus.cyc   = m_bus.cyc;
          s1_bus.stb   = m_bus.stb;
          s1_bus.we    = m_bus.we;
          s1_bus.adr   = m_bus.adr;
          s1_bus.dat_o = m_bus.dat_o;
          m_bus.dat_i  = s1_bus.dat_i;
          m_bus.ack    = s1_bus.ack & m_bus.stb;
          if (!m_bus.stb || s1_bus.ack) begin
            state_nxt = IDLE;
          end else if (tmo_cnt == TMO_LAST) begin
            state_nxt = ERROR;
          end else begin
            tmo_cnt_nxt = tmo_cnt + 8'd1;
          end
        end
        ERROR: begin
          m_bus.ack = 1'b1;
          m_err     = 1'b1;
          state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_decoder.sv
// Randomized bench for data_bus_decoder: a transaction-level model predicts strobe window, ack cycle, read data and error count.
module tb_data_bus_decoder;

  localparam int unsigned TMO     = 4;
  localparam logic [31:0] S0_BASE = 32'h0000_0000;
  localparam logic [31:0] S0_MASK = 32'hFFFF_0000;
  localparam logic [31:0] S1_BASE = 32'h1000_0000;
  localparam logic [31:0] S1_MASK = 32'hFFFF_F000;

  logic       clk = 1'b0;
  logic       rst;
  logic       m_err;
  logic [7:0] err_count;
  logic [5:0] obs_v;

  data_bus_decoder_if m_bus ();
  data_bus_decoder_if s0_bus ();
  data_bus_decoder_if s1_bus ();

  int n_checks    = 0;
  int n_pass      = 0;
  int exp_err_cnt = 0;

  data_bus_decoder #(
    .S0_BASE (S0_BASE),
    .S0_MASK (S0_MASK),
    .S1_BASE (S1_BASE),
    .S1_MASK (S1_MASK),
    .TIMEOUT (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m_bus     (m_bus),
    .s0_bus    (s0_bus),
    .s1_bus    (s1_bus),
    .m_err     (m_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  assign obs_v = {s0_bus.cyc, s0_bus.stb, s1_bus.cyc, s1_bus.stb, m_bus.ack, m_err};

  // 0 = RAM, 1 = I/O, 2 = unmapped; RAM wins when both regions match.
  function automatic int region_of(input logic [31:0] a);
    if ((a & S0_MASK) == S0_BASE) return 0;
    if ((a & S1_MASK) == S1_BASE) return 1;
    return 2;
  endfunction

  task automatic master_idle();
    m_bus.cyc   = 1'b0;
    m_bus.stb   = 1'b0;
    m_bus.we    = 1'b0;
    m_bus.adr   = '0;
    m_bus.dat_o = '0;
  endtask

  // One master transfer; d is the number of strobed cycles before the target slave acks.
  task automatic run_txn(input string name, input logic [31:0] addr, input logic wr,
                         input logic [31:0] wdat, input logic [31:0] rdat, input int d);
    int          region;
    int          fin;
    bit          tmo;
    bit          is_err;
    bit          strobed;
    logic [31:0] other;
    logic [31:0] exp_rd;
    logic [5:0]  exp_v;
    logic [64:0] got_fwd;
    region = region_of(addr);
    tmo    = (region != 2) && (d >= int'(TMO));
    is_err = (region == 2) || tmo;
    fin    = (region == 2) ? 1 : (tmo ? int'(TMO) + 1 : d + 1);
    other  = $urandom;
    @(negedge clk);
    m_bus.cyc     = 1'b1;
    m_bus.stb     = 1'b1;
    m_bus.we      = wr;
    m_bus.adr     = addr;
    m_bus.dat_o   = wdat;
    s0_bus.dat_i  = (region == 1) ? other : rdat;
    s1_bus.dat_i  = (region == 1) ? rdat : other;
    s0_bus.ack    = 1'($urandom);
    s1_bus.ack    = 1'($urandom);
    #1;
    n_checks++;
    if (obs_v !== 6'b0) $display("FAIL %s decode_cycle: got %b expected 000000", name, obs_v);
    else n_pass++;
    for (int k = 1; k <= fin; k++) begin
      @(negedge clk);
      s0_bus.ack = (region == 0) ? (k - 1 == d) : 1'($urandom);
      s1_bus.ack = (region == 1) ? (k - 1 == d) : 1'($urandom);
      #1;
      strobed = (region != 2) && !(tmo && k == fin);
      exp_v = '0;
      if (strobed && region == 0) exp_v[5:4] = 2'b11;
      if (strobed && region == 1) exp_v[3:2] = 2'b11;
      if (k == fin) begin
        exp_v[1] = 1'b1;
        exp_v[0] = is_err;
      end
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL %s cycle%0d controls: got %b expected %b", name, k, obs_v, exp_v);
      else n_pass++;
      if (k == 1 && region != 2) begin
        got_fwd = (region == 0) ? {s0_bus.we, s0_bus.adr, s0_bus.dat_o}
                                : {s1_bus.we, s1_bus.adr, s1_bus.dat_o};
        n_checks++;
        if (got_fwd !== {wr, addr, wdat}) $display("FAIL %s forward: got %h expected %h", name, got_fwd, {wr, addr, wdat});
        else n_pass++;
      end
      if (k == fin) begin
        exp_rd = is_err ? 32'h0 : rdat;
        n_checks++;
        if (m_bus.dat_i !== exp_rd) $display("FAIL %s rdata: got %h expected %h", name, m_bus.dat_i, exp_rd);
        else n_pass++;
      end
    end
    if (is_err && exp_err_cnt < 255) exp_err_cnt++;
  endtask

  task automatic idle_cycle(input string name);
    @(negedge clk);
    master_idle();
    s0_bus.ack = 1'($urandom);
    s1_bus.ack = 1'($urandom);
    #1;
    n_checks++;
    if (obs_v !== 6'b0) $display("FAIL %s idle: got %b expected 000000", name, obs_v);
    else n_pass++;
    n_checks++;
    if (err_count !== 8'(exp_err_cnt)) $display("FAIL %s err_count: got %0d expected %0d", name, err_count, exp_err_cnt);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    master_idle();
    s0_bus.ack   = 1'b0;
    s1_bus.ack   = 1'b0;
    s0_bus.dat_i = 32'h1234_5678;
    s1_bus.dat_i = 32'h9ABC_DEF0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({obs_v, m_bus.dat_i, err_count} !== 46'b0)
      $display("FAIL reset outputs: got %b/%h/%0d expected all zero", obs_v, m_bus.dat_i, err_count);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if ({obs_v, err_count} !== 14'b0) $display("FAIL reset release: got %b/%0d expected zero", obs_v, err_count);
    else n_pass++;
  endtask

  task automatic test_directed();
    run_txn("ram_read", 32'h0000_0100, 1'b0, $urandom, 32'hCAFE_BABE, 2);
    idle_cycle("ram_read");
    run_txn("io_write", 32'h1000_0004, 1'b1, 32'h0000_00A5, $urandom, 1);
    idle_cycle("io_write");
    run_txn("unmapped", 32'h2000_0000, 1'b0, 32'h0, 32'hDEAD_BEEF, 0);
    idle_cycle("unmapped");
    run_txn("timeout", 32'h0000_0200, 1'b0, 32'h0, 32'h5555_AAAA, 1000);
    idle_cycle("timeout");
  endtask

  task automatic test_back_to_back();
    run_txn("pair_lo", 32'h0000_FFFC, 1'b0, 32'h0, 32'h0BAD_F00D, 1);
    run_txn("pair_hi", 32'h0001_0000, 1'b0, 32'h0, 32'h0BAD_F00D, 1);
    idle_cycle("pair");
  endtask

  task automatic test_abort();
    @(negedge clk);
    m_bus.cyc   = 1'b1;
    m_bus.stb   = 1'b1;
    m_bus.we    = 1'b1;
    m_bus.adr   = 32'h1000_0008;
    m_bus.dat_o = 32'h0000_0077;
    s0_bus.ack  = 1'b0;
    s1_bus.ack  = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (obs_v !== 6'b001100) $display("FAIL abort strobe%0d: got %b expected 001100", k, obs_v);
      else n_pass++;
    end
    @(negedge clk);
    master_idle();
    #1;
    n_checks++;
    if (obs_v !== 6'b0) $display("FAIL abort drop: got %b expected 000000", obs_v);
    else n_pass++;
    idle_cycle("abort");
    run_txn("after_abort", 32'h1000_0010, 1'b0, 32'h0, 32'h0000_1111, 0);
    idle_cycle("after_abort");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    m_bus.cyc   = 1'b1;
    m_bus.stb   = 1'b1;
    m_bus.we    = 1'b0;
    m_bus.adr   = 32'h0000_0040;
    s0_bus.ack  = 1'b0;
    s1_bus.ack  = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (obs_v !== 6'b110000) $display("FAIL rst_mid strobe: got %b expected 110000", obs_v);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({obs_v, s0_bus.adr, m_bus.dat_i} !== 70'b0)
      $display("FAIL rst_mid during: got %b/%h/%h expected zero", obs_v, s0_bus.adr, m_bus.dat_i);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    master_idle();
    exp_err_cnt = 0;
    #1;
    n_checks++;
    if ({obs_v, err_count} !== 14'b0) $display("FAIL rst_mid after: got %b/%0d expected zero", obs_v, err_count);
    else n_pass++;
    idle_cycle("rst_mid");
  endtask

  task automatic test_random();
    logic [31:0] edges [4];
    logic [31:0] addr;
    edges[0] = 32'h0000_FFFC;
    edges[1] = 32'h1000_0FFC;
    edges[2] = 32'h1000_1000;
    edges[3] = 32'h0001_0000;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0:       addr = {16'h0000, 16'($urandom)};
        1:       addr = {20'h10000, 12'($urandom)};
        2:       addr = edges[$urandom_range(0, 3)];
        default: addr = $urandom | 32'h2000_0000;
      endcase
      run_txn("random", addr, 1'($urandom), $urandom, $urandom, $urandom_range(0, 5));
      if ($urandom_range(0, 1) == 0) idle_cycle("random");
    end
    idle_cycle("random_end");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 260; i++) begin
      run_txn("sat", 32'h3000_0000 | 32'(i), 1'b1, $urandom, 32'h0, 0);
    end
    idle_cycle("saturation");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
